// File: rtl/imem_boot_loader.sv
// Boot loader: takes a length-prefixed, XOR-checksummed byte stream, writes
// little-endian words to imem from address 0, then releases the core PC.
module imem_boot_loader #(
  parameter int ADDR_W    = 9,
  parameter int MAX_WORDS = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              we0,
  output logic [ADDR_W-1:0] wr_addr0,
  output logic [31:0]       wr_din0,
  output logic              resetpc,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {IDLE, LEN0, LEN1, BYTE, WRITE, CSUM, RUN, ERR} state_t;

  state_t      state;
  logic [15:0] count;
  logic [15:0] word_idx;
  logic [1:0]  k;
  logic [23:0] word;
  logic [7:0]  csum;
  logic        xfer;

  assign xfer = in_valid && in_ready;

  // Status outputs are flops loaded from the next state, so they change
  // in the same cycle the state register does.
  always_ff @(posedge clk or posedge reset) begin
    state_t nxt;
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      word_idx <= '0;
      k        <= '0;
      word     <= '0;
      csum     <= '0;
      we0      <= 1'b0;
      wr_addr0 <= '0;
      wr_din0  <= '0;
      resetpc  <= 1'b0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      nxt = state;
      case (state)
        IDLE, RUN, ERR: if (start) begin
          nxt      = LEN0;
          csum     <= '0;
          word_idx <= '0;
          k        <= '0;
        end
        LEN0: if (xfer) begin
          count[7:0] <= in_data;
          csum       <= csum ^ in_data;
          nxt        = LEN1;
        end
        LEN1: if (xfer) begin
          count[15:8] <= in_data;
          csum        <= csum ^ in_data;
          if ({in_data, count[7:0]} > 16'(MAX_WORDS)) nxt = ERR;
          else if ({in_data, count[7:0]} == 16'd0)    nxt = CSUM;
          else                                         nxt = BYTE;
        end
        BYTE: if (xfer) begin
          csum <= csum ^ in_data;
          k    <= k + 2'd1;
          case (k)
            2'd0: word[7:0]   <= in_data;
            2'd1: word[15:8]  <= in_data;
            2'd2: word[23:16] <= in_data;
            default: begin
              wr_din0  <= {in_data, word};
              wr_addr0 <= ADDR_W'({word_idx, 2'b00});
              nxt      = WRITE;
            end
          endcase
        end
        WRITE: begin
          word_idx <= word_idx + 16'd1;
          k        <= '0;
          nxt      = (word_idx + 16'd1 == count) ? CSUM : BYTE;
        end
        CSUM: if (xfer) nxt = (in_data == csum) ? RUN : ERR;
        default: nxt = IDLE;
      endcase
      state    <= nxt;
      in_ready <= (nxt == LEN0) || (nxt == LEN1) || (nxt == BYTE) || (nxt == CSUM);
      busy     <= (nxt == LEN0) || (nxt == LEN1) || (nxt == BYTE) || (nxt == WRITE) || (nxt == CSUM);
      we0      <= (nxt == WRITE);
      resetpc  <= (nxt == RUN);
      done     <= (nxt == RUN);
      error    <= (nxt == ERR);
    end
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Boot sequencer for the pipelined RV32 core's instruction memory port (we0 / wr_addr0 / wr_din0) and its resetpc run-enable.
- Accepts a length-prefixed, checksummed byte stream and assembles little-endian 32-bit words.
- Writes each word to consecutive word-aligned addresses, then releases resetpc so the core fetches from address 0.
- Replaces hand-driven memory loading in benches and on board.

Parameters:
ADDR_W, 9, width of wr_addr0 (byte address)
MAX_WORDS, 128, largest accepted word count; must satisfy MAX_WORDS*4 <= 2**ADDR_W

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state
start  input  1  level-sampled load request (acted on in IDLE, RUN, ERR)
in_valid  input  1  byte stream valid
in_data  input  8  byte stream data
in_ready  output  1  loader can accept a byte this cycle
we0  output  1  imem write enable, one-cycle pulse per word
wr_addr0  output  ADDR_W  imem byte address, always a multiple of 4
wr_din0  output  32  imem write data
resetpc  output  1  core run enable (0 = core PC held at reset)
busy  output  1  load in progress
done  output  1  load completed with good checksum
error  output  1  load aborted (bad count or checksum)

Behaviour:
- Reset (async, active-high): state=IDLE; we0=0, wr_addr0=0, wr_din0=0, resetpc=0, in_ready=0, busy=0, done=0, error=0; count, word index, byte index and checksum cleared. Reset mid-load abandons the load; words already written stay in memory.
- Byte transfer occurs on a rising edge with in_valid && in_ready. in_ready is a pure function of state: 1 in LEN0, LEN1, BYTE, CSUM; 0 otherwise. in_data is ignored when no transfer occurs.
- Stream format: count_lo, count_hi (16-bit word count N, little-endian), then 4*N word bytes (LSB first), then one checksum byte. Checksum = XOR of every preceding byte in the stream, including the count bytes.
- IDLE: start=1 -> LEN0 on the next edge; busy=1 from LEN0 onward; checksum and word index cleared.
- LEN0: on transfer, latch count[7:0] -> LEN1.
- LEN1: on transfer, latch count[15:8].
  - N > MAX_WORDS -> ERR.
  - N = 0 -> CSUM.
  - Otherwise -> BYTE.
- BYTE: on each transfer, shift the byte into word[8*k +: 8], k = 0..3. After k=3 -> WRITE.
- WRITE (exactly one cycle): we0=1, wr_addr0=4*word_idx, wr_din0=assembled word; word_idx increments. If word_idx+1 = N -> CSUM, else -> BYTE with k=0. we0 is 0 in every other state; wr_addr0/wr_din0 hold their last values.
- CSUM: on transfer, compare the byte with the running XOR.
  - Equal -> RUN.
  - Not equal -> ERR.
- RUN: resetpc=1, done=1, busy=0, starting the cycle after the checksum transfer. start=1 -> resetpc=0, done=0, go to LEN0 (reload).
- ERR: error=1, resetpc=0, busy=0. start=1 -> clear error, go to LEN0.
- start is ignored in LEN0/LEN1/BYTE/WRITE/CSUM.
- Throughput: 5 cycles per word minimum (4 byte transfers + 1 WRITE). Stalls on in_valid=0 are unbounded and do not change state.
- Address wrap is impossible: count is checked against MAX_WORDS before any write. Last address = 4*(MAX_WORDS-1) = 508.

Test Plan:
- Single word, back-to-back valid: bytes 01 00 13 00 00 00 12 -> one we0 pulse, wr_addr0=0, wr_din0=0x00000013; in_ready=0 that cycle; resetpc=1 and done=1 the cycle after byte 0x12.
- Three words 0x00500093, 0x00A00113, 0x002081B3 with in_valid toggled every other cycle -> writes at addresses 0, 4, 8 in order, each exactly once; resetpc stays 0 until the checksum is accepted.
- Bad checksum: same stream as the first test with last byte 0x13 -> error=1, done=0, resetpc=0; next start -> error clears, reload of a good stream succeeds.
- Count 129 (bytes 81 00) -> ERR immediately after the second byte, no we0 pulse, in_ready=0 afterward.
- Count 0 (bytes 00 00 00) -> no writes, done=1, resetpc=1.
- Reset asserted mid-word (after 2 of 4 bytes) -> all outputs 0 asynchronously, state IDLE; start plus a full stream reloads from address 0.
